// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: registers and isolates operands, waits SETTLE_CYCLES,
// captures the result and holds it under valid/ready until consumed; one operation in flight.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_A,
  input  logic [3:0] in_B,
  input  logic [3:0] in_Sel,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] Sel,
  input  logic [5:0] Y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_Y,
  output logic [3:0] out_Sel,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_HOLD
  } state_t;

  localparam logic [2:0] SETTLE_LD = 3'(SETTLE_CYCLES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_sel;
  logic [5:0] r_out_y;
  logic [3:0] r_out_sel;
  logic       r_out_valid;
  logic [7:0] r_op_count;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_capture;
  logic       w_consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture = (r_cnt == 3'd1);
        if (w_capture) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A new operation may enter on the same edge the result leaves: no idle bubble.
        w_in_ready = out_ready;
        w_consume  = out_ready;
        if (out_ready) begin
          w_state_nxt = in_valid ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept = in_valid && w_in_ready;

  // Operands change only on accept so the ALU inputs never toggle otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_sel       <= 4'd0;
      r_cnt       <= 3'd0;
      r_out_y     <= 6'd0;
      r_out_sel   <= 4'd0;
      r_out_valid <= 1'b0;
      r_op_count  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_a   <= in_A;
        r_b   <= in_B;
        r_sel <= in_Sel;
        r_cnt <= SETTLE_LD;
      end else if (r_state == ST_EXEC) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_capture) begin
        r_out_y     <= Y;
        r_out_sel   <= r_sel;
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
        r_op_count  <= r_op_count + 8'd1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign A         = r_a;
  assign B         = r_b;
  assign Sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_Y     = r_out_y;
  assign out_Sel   = r_out_sel;
  assign busy      = (r_state != ST_IDLE);
  assign op_count  = r_op_count;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1, number of clock cycles operands are held on the ALU before Y is sampled; legal range 1..7.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream offers an operation.
REQ-005 in_ready  output  1  block accepts the operation this cycle.
REQ-006 in_A  input  4  operand A request.
REQ-007 in_B  input  4  operand B request.
REQ-008 in_Sel  input  4  operation select request (Sel[3]=0 arithmetic, 1 logical).
REQ-009 A  output  4  registered operand A driven to the ALU.
REQ-010 B  output  4  registered operand B driven to the ALU.
REQ-011 Sel  output  4  registered select driven to the ALU.
REQ-012 Y  input  6  combinational ALU result.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream consumes result.
REQ-015 out_Y  output  6  captured result.
REQ-016 out_Sel  output  4  select that produced out_Y.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 op_count  output  8  count of completed (consumed) operations.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, HOLD; encoding free.
REQ-020 Accept SHALL occur on a rising edge where in_valid && in_ready.
REQ-021 in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, 0 in EXEC.
REQ-022 On accept, A/B/Sel SHALL load in_A/in_B/in_Sel, settle counter SHALL load SETTLE_CYCLES, state SHALL go to EXEC.
REQ-023 A/B/Sel SHALL change only on accept (operand isolation: no ALU input toggling otherwise, whatever in_* do).
REQ-024 EXEC: counter decrements each cycle; on the edge where counter==1, out_Y<=Y, out_Sel<=Sel, out_valid<=1, state->HOLD.
REQ-025 Latency: accept at edge N -> out_valid high after edge N+SETTLE_CYCLES.
REQ-026 HOLD: out_valid, out_Y, out_Sel SHALL stay stable until out_valid && out_ready.
REQ-027 Consume edge with no accept: out_valid<=0, op_count++, state->IDLE.
REQ-028 Consume and accept same edge: op_count++, out_valid<=0, new operands load, state->EXEC (no idle bubble).
REQ-029 op_count SHALL wrap 255 -> 0 without saturating.
REQ-030 in_valid while in EXEC SHALL be ignored (not accepted, no state change).
REQ-031 Y SHALL be sampled only per REQ-024; Y changes at other times have no effect.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, A=B=Sel=0, out_Y=0, out_Sel=0, out_valid=0, op_count=0, settle counter=0, busy=0, in_ready=1.
REQ-033 Reset mid-EXEC or mid-HOLD SHALL discard the pending operation; first accept after rst_n rises behaves as from power-up.

Verification (bench connects A/B/Sel/Y to the team ALU)
REQ-034 SETTLE=1, in_A=0010 in_B=0001 in_Sel=0000 accepted, out_ready=1 -> out_valid after 1 edge, out_Y=000011, out_Sel=0000, op_count=1.
REQ-035 in_A=0010 in_B=0011 in_Sel=1111, out_ready=0 for 5 cycles while in_* toggle -> out_Y=111010 held, in_ready=0, A/B/Sel held 0010/0011/1111, op_count unchanged until out_ready=1.
REQ-036 Back-to-back: HOLD with out_ready=1 and in_valid=1 (in_A=0010 in_B=0011 in_Sel=0110) -> same-edge consume+accept, next out_Y=000101, no IDLE cycle.
REQ-037 SETTLE_CYCLES=4 -> out_valid rises exactly 4 edges after accept; in_valid during EXEC not accepted.
REQ-038 rst_n pulsed low during EXEC -> all outputs reset values at once, no out_valid; 256 consumed ops from reset -> op_count=0.
